ifetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end for the 5-stage RV32 pipeline: owns the fetch PC, issues

---
 rtl/ifetch_queue_pkg.sv | 13 +
 rtl/ifetch_queue_fetch_fifo.sv | 62 ++++++
 rtl/ifetch_queue.sv | 142 ++++++++++++++
 tb/tb_ifetch_queue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package ifetch_queue_pkg;

  localparam int          IFQ_XLEN       = 32;
  localparam logic [31:0] IFQ_INITIAL_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_COLD  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } ifq_state_e;

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs between fetch and decode.
// The head output holds its last shown value while the FIFO is empty.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  last_head;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  assign head_data = empty ? last_head : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_head <= '0;
    end else begin
      last_head <= head_data;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues pipelined imem
// requests and queues returned words with their PCs for decode.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_COLD  | one idle cycle after reset, no requests
// ST_FETCH | issuing requests while credit allows, responses enqueued
// ST_DRAIN | after a redirect, dropping responses of stale requests
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int               XLEN       = IFQ_XLEN,
  parameter int               DEPTH      = 4,
  parameter int               MAX_OUTST  = 2,
  parameter logic [XLEN-1:0]  INITIAL_PC = XLEN'(IFQ_INITIAL_PC)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready
);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_e      state;
  ifq_state_e      state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   discard;
  logic [OW-1:0]   discard_nxt;
  logic [OW-1:0]   out_after_rsp;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [2*XLEN-1:0] fifo_head;

  logic            rsp_take;
  logic            rsp_drop;
  logic            can_issue;
  logic            grant;
  logic [XLEN-1:0] redirect_aligned;
  logic [1:0]      unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];
  assign redirect_aligned    = {redirect_pc[XLEN-1:2], 2'b00};

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_take  = imem_rvalid && (outstanding != '0);
  assign rsp_drop  = rsp_take && (redirect_valid || (discard != '0));
  assign fifo_push = rsp_take && !rsp_drop;
  assign fifo_pop  = !fifo_empty && id_ready && !redirect_valid;

  // Credit: every accepted request must already own a FIFO slot.
  assign can_issue = (32'(outstanding) < MAX_OUTST) &&
                     ((32'(fifo_count) + 32'(outstanding)) < DEPTH);
  assign imem_req  = (state == ST_FETCH) && !redirect_valid && can_issue;
  assign grant     = imem_req && imem_gnt;
  assign imem_addr = fetch_pc;

  assign out_after_rsp = outstanding - OW'(rsp_take);

  assign id_valid = !fifo_empty;
  assign id_pc    = fifo_head[2*XLEN-1:XLEN];
  assign id_instr = fifo_head[XLEN-1:0];

  always_comb begin
    discard_nxt = discard;
    if (redirect_valid) begin
      discard_nxt = out_after_rsp;
    end else if (rsp_take && (discard != '0)) begin
      discard_nxt = discard - OW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLD:  state_nxt = ST_FETCH;
      ST_FETCH: if (redirect_valid && (out_after_rsp != '0)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (discard_nxt == '0) state_nxt = ST_FETCH;
      default:  state_nxt = ST_COLD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_COLD;
      fetch_pc    <= INITIAL_PC;
      resp_pc     <= INITIAL_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_nxt;
      discard     <= discard_nxt;
      outstanding <= out_after_rsp + OW'(grant);
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        resp_pc  <= redirect_aligned;
      end else begin
        if (grant)     fetch_pc <= fetch_pc + XLEN'(4);
        if (fifo_push) resp_pc  <= resp_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .W     (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (fifo_push),
    .push_data ({resp_pc, imem_rdata}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always @(posedge clock) begin
    if (reset) begin
      assert (!(imem_rvalid && (outstanding == '0)));
      assert (!(fifo_push && fifo_full));
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: an imem model answers grants, and a
// scoreboard of expected PCs is checked against every word decode consumes.
module tb_ifetch_queue;
  localparam int XLEN = 32;

  logic            clock;
  logic            reset;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic            id_ready;

  ifetch_queue #(
    .XLEN       (XLEN),
    .DEPTH      (4),
    .MAX_OUTST  (2),
    .INITIAL_PC (32'h0000_0000)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_pass = 0;
  int          n_total = 0;
  int          pops = 0;
  logic [31:0] sb_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] exp_req_pc;
  logic [31:0] last_pop_pc;
  logic        k_gnt, k_ready, k_rsp, k_redir;
  logic [31:0] k_target;

  function automatic logic [31:0] mix(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: drive inputs at the falling edge, then score what the DUT shows.
  task automatic step();
    logic [31:0] e;
    @(negedge clock);
    redirect_valid = k_redir;
    redirect_pc    = k_target;
    imem_gnt       = k_gnt;
    id_ready       = k_ready;
    if (k_rsp && (mem_q.size() > 0)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mix(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    if (k_redir) begin
      check("req_during_redirect", {31'b0, imem_req}, 32'd0);
      sb_q.delete();
      exp_req_pc = {k_target[31:2], 2'b00};
    end else begin
      if (id_valid && id_ready) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $error("FAIL spurious_pop observed_pc=%h expected=none", id_pc);
        end else begin
          e = sb_q.pop_front();
          check("id_pc", id_pc, e);
          check("id_instr", id_instr, mix(e));
          last_pop_pc = e;
          pops++;
        end
      end
      if (imem_req && imem_gnt) begin
        check("imem_addr", imem_addr, exp_req_pc);
        mem_q.push_back(imem_addr);
        sb_q.push_back(exp_req_pc);
        exp_req_pc = exp_req_pc + 32'd4;
      end
    end
  endtask

  initial begin
    int p0;
    bit seen;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    id_ready       = 1'b0;
    exp_req_pc     = 32'h0;
    last_pop_pc    = 32'h0;
    k_gnt = 1'b1; k_ready = 1'b1; k_rsp = 1'b1; k_redir = 1'b0; k_target = '0;

    #12;
    check("rst_req",      {31'b0, imem_req}, 32'd0);
    check("rst_addr",     imem_addr, 32'h0);
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_pc",    id_pc, 32'h0);

    @(negedge clock);
    reset = 1'b1;
    #1;
    check("cold_req", {31'b0, imem_req}, 32'd0);

    // Streaming with single-cycle memory
    step();
    check("first_req", {31'b0, imem_req}, 32'd1);
    repeat (9) step();
    p0 = pops;
    repeat (20) step();
    check("throughput", 32'(pops - p0), 32'd20);

    // Decode stall fills the queue, then drains exactly DEPTH entries
    k_ready = 1'b0;
    repeat (10) step();
    check("stall_req_off", {31'b0, imem_req}, 32'd0);
    check("stall_valid",   {31'b0, id_valid}, 32'd1);
    k_ready = 1'b1;
    k_gnt   = 1'b0;
    p0 = pops;
    repeat (8) step();
    check("stall_buffered", 32'(pops - p0), 32'd4);
    check("drained_valid",  {31'b0, id_valid}, 32'd0);
    check("hold_id_pc",     id_pc, last_pop_pc);
    check("sb_drained",     32'(sb_q.size()), 32'd0);

    // Grant held low: address must stay put
    repeat (5) begin
      step();
      check("gnt_low_req",  {31'b0, imem_req}, 32'd1);
      check("gnt_low_addr", imem_addr, exp_req_pc);
    end
    k_gnt = 1'b1;
    repeat (6) step();

    // Redirect with two requests outstanding
    k_rsp = 1'b0;
    step();
    step();
    check("outst_limit_req", {31'b0, imem_req}, 32'd0);
    k_redir = 1'b1; k_target = 32'h0000_0103;
    step();
    k_redir = 1'b0; k_rsp = 1'b1;
    step();
    check("drain1_req",   {31'b0, imem_req}, 32'd0);
    check("drain1_valid", {31'b0, id_valid}, 32'd0);
    step();
    check("drain2_req", {31'b0, imem_req}, 32'd0);
    step();
    check("refetch_req",  {31'b0, imem_req}, 32'd1);
    check("refetch_addr", imem_addr, 32'h0000_0100);
    repeat (8) step();

    // Redirect coinciding with a response and a pop
    k_rsp = 1'b0; k_ready = 1'b0;
    step();
    k_rsp = 1'b1; k_ready = 1'b1; k_redir = 1'b1; k_target = 32'h0000_0200;
    step();
    check("t4_pre_valid",  {31'b0, id_valid}, 32'd1);
    check("t4_pre_rvalid", {31'b0, imem_rvalid}, 32'd1);
    k_redir = 1'b0;
    step();
    check("t4_flushed", {31'b0, id_valid}, 32'd0);
    check("t4_drain",   {31'b0, imem_req}, 32'd0);
    step();
    check("t4_refetch_req",  {31'b0, imem_req}, 32'd1);
    check("t4_refetch_addr", imem_addr, 32'h0000_0200);
    repeat (8) step();

    // PC wrap at the top of the address space
    k_redir = 1'b1; k_target = 32'hFFFF_FFF8;
    step();
    k_redir = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      if (imem_req && imem_gnt && (imem_addr == 32'hFFFF_FFFC)) seen = 1'b1;
    end
    if (!seen) begin
      n_total++;
      $error("FAIL wrap_grant observed=none expected=grant_of_fffffffc");
    end else begin
      step();
      check("wrap_addr", imem_addr, 32'h0000_0000);
    end
    repeat (8) step();
    k_gnt = 1'b0;
    repeat (8) step();
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    check("final_valid",    {31'b0, id_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
